// File: rtl/digital_port_pkg.sv
// Shared definitions for the digital I/O port: default pin count and bus write decode.
package digital_port_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef struct packed {
        logic load_out;
        logic load_dir;
    } write_req_t;

    // Both strobes may be active together; each is qualified by the chip select.
    function automatic write_req_t decode_write(input logic cs, input logic wio, input logic wdir);
        write_req_t req;
        req.load_out = cs & wio;
        req.load_dir = cs & wdir;
        return req;
    endfunction

endpackage

// File: rtl/digital_port_sync_2ff.sv
// Two-flop synchronizer bringing asynchronous pin levels into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/digital_port.sv
// Memory-mapped bidirectional GPIO port: output-value and direction registers,
// per-pin tri-state drive and a synchronized read-back path.
module digital_port
    import digital_port_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipSelect,
    input  logic             writeIO,
    input  logic             writeDirection,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    inout  wire  [WIDTH-1:0] IOPort
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] sync_val;
    write_req_t       req;

    assign req = decode_write(chipSelect, writeIO, writeDirection);

    // OUT keeps accepting writes while a pin is an input, so the value is ready when it turns around.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg <= '0;
            dir_reg <= '0;
        end else begin
            if (req.load_out) out_reg <= dataIn;
            if (req.load_dir) dir_reg <= dataIn;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pin
            assign IOPort[i] = dir_reg[i] ? out_reg[i] : 1'bz;
        end
    endgenerate

    sync_2ff #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (IOPort),
        .q    (sync_val)
    );

    // Output pins read back the register value, not the synchronized pin level.
    always_comb begin
        dataOut = (dir_reg & out_reg) | (~dir_reg & sync_val);
    end

endmodule

// File: tb/tb_digital_port.sv
// Randomized self-checking bench for digital_port against a cycle-level reference model.
module tb_digital_port;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         chip_select;
    logic         write_io;
    logic         write_direction;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    wire  [W-1:0] io_pins;

    logic [W-1:0] tb_drv;
    logic [W-1:0] tb_en;

    logic [W-1:0] m_out;
    logic [W-1:0] m_dir;
    logic [W-1:0] m_s1;
    logic [W-1:0] m_s2;

    int vector_count;
    int fail_count;

    digital_port #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .chipSelect    (chip_select),
        .writeIO       (write_io),
        .writeDirection(write_direction),
        .dataIn        (data_in),
        .dataOut       (data_out),
        .IOPort        (io_pins)
    );

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_drv
            assign io_pins[gi] = tb_en[gi] ? tb_drv[gi] : 1'bz;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vector_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // The bench drives every pin the port should leave floating, so any pin value is fully known.
    task automatic settle(input logic [W-1:0] pins);
        @(negedge clk);
        tb_drv = pins;
        tb_en  = ~m_dir;
        #1;
        checkOutput("pins", io_pins, (m_out & m_dir) | (pins & ~m_dir));
        checkOutput("data_out", data_out, (m_out & m_dir) | (m_s2 & ~m_dir));
    endtask

    task automatic clockIn(input logic cs, input logic wio, input logic wdir, input logic [W-1:0] data);
        logic [W-1:0] pin_now;
        chip_select     = cs;
        write_io        = wio;
        write_direction = wdir;
        data_in         = data;
        @(posedge clk);
        pin_now = (m_out & m_dir) | (tb_drv & ~m_dir);
        m_s2 = m_s1;
        m_s1 = pin_now;
        if (cs && wio)  m_out = data;
        if (cs && wdir) m_dir = data;
    endtask

    task automatic applyStimulus(input logic cs, input logic wio, input logic wdir,
                                 input logic [W-1:0] data, input logic [W-1:0] pins);
        settle(pins);
        clockIn(cs, wio, wdir, data);
    endtask

    initial begin
        vector_count    = 0;
        fail_count      = 0;
        reset           = 1'b1;
        chip_select     = 1'b0;
        write_io        = 1'b0;
        write_direction = 1'b0;
        data_in         = '0;
        tb_drv          = '0;
        tb_en           = '1;
        m_out = '0; m_dir = '0; m_s1 = '0; m_s2 = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data_out", data_out, 32'h0);
        checkOutput("reset_pins", io_pins, 32'h0);
        reset = 1'b0;

        // Low byte becomes output, then an OUT write shows only there
        applyStimulus(1, 0, 1, 32'h000000FF, 32'h0);
        applyStimulus(1, 1, 0, 32'h12345678, 32'h0);
        settle(32'hCAFE0000);
        checkOutput("out_write_pins", io_pins, 32'hCAFE0078);
        checkOutput("out_write_low", data_out & 32'hFF, 32'h78);
        clockIn(0, 0, 0, 32'h0);

        // Unselected write is ignored, selected one lands
        settle(32'h0);
        clockIn(0, 1, 0, 32'hFFFFFFFF);
        applyStimulus(1, 0, 1, 32'hFFFFFFFF, 32'h0);
        settle(32'h0);
        checkOutput("unselected_write", data_out, 32'h12345678);
        clockIn(1, 1, 0, 32'hFFFFFFFF);
        settle(32'h0);
        checkOutput("selected_write", data_out, 32'hFFFFFFFF);
        clockIn(0, 0, 0, 32'h0);

        applyStimulus(1, 1, 1, 32'h0000000F, 32'h0);
        settle(32'h0);
        checkOutput("both_strobes_pins", io_pins, 32'h0000000F);
        clockIn(0, 0, 0, 32'h0);

        // Input path latency with all pins as inputs
        applyStimulus(1, 0, 1, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        settle(32'hDEADBEEF);
        clockIn(0, 0, 0, 32'h0);
        settle(32'hDEADBEEF);
        checkOutput("input_one_edge", data_out, 32'h0);
        clockIn(0, 0, 0, 32'h0);
        settle(32'hDEADBEEF);
        checkOutput("input_two_edges", data_out, 32'hDEADBEEF);
        clockIn(0, 0, 0, 32'h0);

        // Pin 0 turns from output (driving 1) to input (bench drives 0)
        applyStimulus(1, 1, 1, 32'h1, 32'h0);
        settle(32'h0);
        checkOutput("pin0_driven", io_pins & 32'h1, 32'h1);
        clockIn(1, 0, 1, 32'h0);
        settle(32'h0);
        checkOutput("pin0_released", io_pins & 32'h1, 32'h0);
        clockIn(0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        settle(32'h0);
        checkOutput("pin0_synced", data_out & 32'h1, 32'h0);
        clockIn(0, 0, 0, 32'h0);

        // Asynchronous reset mid-run with every pin driving; a concurrent write is lost
        applyStimulus(1, 1, 1, 32'hA5A5A5A5, 32'h0);
        applyStimulus(1, 0, 1, 32'hFFFFFFFF, 32'h0);
        settle(32'h0);
        tb_en = '1;
        tb_drv = '0;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_pins", io_pins, 32'h0);
        checkOutput("async_reset_data_out", data_out, 32'h0);
        m_out = '0; m_dir = '0; m_s1 = '0; m_s2 = '0;
        chip_select = 1'b1;
        write_io    = 1'b1;
        data_in     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        checkOutput("write_during_reset", data_out, 32'h0);
        reset       = 1'b0;
        chip_select = 1'b0;
        write_io    = 1'b0;
        applyStimulus(1, 1, 1, 32'h5A5A5A5A, 32'h0);
        settle(32'h0);
        checkOutput("first_write_after_reset", data_out, 32'h5A5A5A5A);
        clockIn(0, 0, 0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) == 0, $urandom, $urandom);
        end
        settle(32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule

// File: doc/digital_port.md
DIGITAL_PORT -- requirements
Module: digital_port

Interface
REQ-001 Parameter: WIDTH, default 32, number of I/O pins and data-bus width.
REQ-002 clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 chipSelect  input  1  port selected by bus address decode.
REQ-005 writeIO  input  1  write strobe for the output-value register (bus offset 0x0).
REQ-006 writeDirection  input  1  write strobe for the direction register (bus offset 0x4).
REQ-007 dataIn  input  WIDTH  bus write data.
REQ-008 dataOut  output  WIDTH  bus read data.
REQ-009 IOPort  inout  WIDTH  bidirectional pins.

Function
REQ-010 The block SHALL hold an output-value register OUT[WIDTH-1:0] and a direction register DIR[WIDTH-1:0]; DIR bit 1 = output, 0 = input.
REQ-011 On a rising clk edge, if chipSelect && writeIO, OUT SHALL load dataIn; the new value drives the pins from the following cycle.
REQ-012 On a rising clk edge, if chipSelect && writeDirection, DIR SHALL load dataIn.
REQ-013 If both strobes are asserted in the same cycle with chipSelect, OUT and DIR SHALL both load dataIn.
REQ-014 Strobes without chipSelect SHALL be ignored; chipSelect without a strobe SHALL change no state.
REQ-015 Per bit i: IOPort[i] SHALL equal OUT[i] when DIR[i]=1 and SHALL be high-impedance when DIR[i]=0.
REQ-016 Each IOPort bit SHALL pass through a two-flop synchronizer to form SYNC[WIDTH-1:0]; pin-to-SYNC latency is exactly 2 rising edges.
REQ-017 dataOut SHALL be combinational: per bit i, dataOut[i] = DIR[i] ? OUT[i] : SYNC[i].
REQ-018 dataOut SHALL be driven regardless of chipSelect; the bus read mux qualifies it.
REQ-019 Changing DIR[i] from 1 to 0 SHALL release pin i to high impedance in the next cycle; dataOut[i] then reflects SYNC[i], with its 2-cycle latency.
REQ-020 Changing DIR[i] from 0 to 1 SHALL drive the current OUT[i] on pin i in the next cycle, without glitching to another value.
REQ-021 A write to OUT while DIR=0 SHALL still update OUT; the value appears on the pins when DIR is later set.

Reset
REQ-022 While reset=1, OUT, DIR and all synchronizer flops SHALL be 0 immediately (asynchronous), independent of clk.
REQ-023 During and after reset, all pins SHALL be high-impedance (DIR=0) and dataOut SHALL be 0 until synchronized inputs propagate.
REQ-024 Reset asserted in the same cycle as a write SHALL take priority; the write is lost.
REQ-025 Deassertion SHALL be usable without glitches; the first write is accepted on the first rising edge after reset falls.

Structure
REQ-026 No shared package is required; WIDTH is the only configurable constant. Bus offsets 0x0/0x4 are decoded outside the block and belong in the system address-map package.
REQ-027 One sub-module, sync_2ff (WIDTH-bit, async active-high reset to 0), SHALL implement the input synchronizer.
REQ-028 Tri-state drive SHALL be a per-bit continuous assignment in digital_port; there SHALL be no internal tri-states elsewhere.

Verification
REQ-029 Reset: assert reset mid-run with DIR=0xFFFFFFFF, OUT=0xA5A5A5A5 -> IOPort all Z and dataOut=0 immediately, no clock edge needed.
REQ-030 Output write: DIR<=0x000000FF, then OUT<=0x12345678 (chipSelect=1) -> next cycle IOPort[7:0]=0x78, IOPort[31:8]=Z, dataOut[7:0]=0x78.
REQ-031 Input path: DIR=0, bench drives IOPort=0xDEADBEEF -> dataOut=0 after 1 edge, 0xDEADBEEF after 2 edges.
REQ-032 Qualification: writeIO=1, chipSelect=0, dataIn=0xFFFFFFFF -> OUT unchanged; repeat with chipSelect=1 -> OUT=0xFFFFFFFF.
REQ-033 Simultaneous strobes: writeIO=writeDirection=chipSelect=1, dataIn=0x0000000F -> OUT=DIR=0x0000000F; IOPort[3:0]=0xF next cycle.
REQ-034 Direction flip: OUT=1, DIR bit0 1->0, bench drives pin0=0 -> IOPort[0] Z next cycle, dataOut[0]=0 two edges later.
